// File: rtl/mi_sequencer.sv
// mi_sequencer: microinstruction sequencer. FETCH captures a control word
// and its address operand, EXEC decodes it (branch, plain commit, memory
// access or illegal), MEM holds a memory request until mem_ack.
// Optional build macro MI_SEQUENCER_TIMEOUT_EN adds a 15-cycle ack timeout.
module mi_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [32:0] micro_instruction,
  input  logic [10:0] data_addr,
  output logic        HOLD,
  input  logic        zf,
  input  logic        cy,
  output logic [10:0] pc,
  output logic [3:0]  alu_op,
  output logic [1:0]  sh,
  output logic        kmx,
  output logic [4:0]  bus_a,
  output logic [5:0]  bus_b,
  output logic [5:0]  bus_c,
  output logic        ctrl_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [10:0] mem_addr,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2} state_e;

  state_e      state_q;
  logic [10:0] pc_q, addr_q, mem_addr_q;
  logic [6:0]  t_q;
  logic        mr_q, mw_q;
  logic [3:0]  alu_q;
  logic [1:0]  sh_q;
  logic        kmx_q;
  logic [4:0]  bus_a_q;
  logic [5:0]  bus_b_q, bus_c_q;
  logic        hold_q, cv_q, mem_req_q, mem_we_q, err_q;
`ifdef MI_SEQUENCER_TIMEOUT_EN
  logic [3:0]  tmo_cnt_q;
`endif

  logic        br_taken;
  logic [10:0] pc_inc;

  // Branch decision on the captured T_word; flags are live during EXEC.
  // pc_inc wraps 2047 -> 0 through natural 11-bit overflow.
  always_comb begin
    br_taken = t_q[6] & ((t_q[5:0] == 6'd0) | (t_q[0] & zf) | (t_q[4] & cy));
    pc_inc   = pc_q + 11'd1;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      t_q        <= '0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      alu_q      <= '0;
      sh_q       <= '0;
      kmx_q      <= 1'b0;
      bus_a_q    <= '0;
      bus_b_q    <= '0;
      bus_c_q    <= '0;
      hold_q     <= 1'b0;
      cv_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef MI_SEQUENCER_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      cv_q <= 1'b0;
      case (state_q)
        FETCH: begin
          alu_q   <= micro_instruction[32:29];
          sh_q    <= micro_instruction[28:27];
          kmx_q   <= micro_instruction[26];
          mr_q    <= micro_instruction[25];
          mw_q    <= micro_instruction[24];
          bus_b_q <= micro_instruction[23:18];
          bus_c_q <= micro_instruction[17:12];
          t_q     <= micro_instruction[11:5];
          bus_a_q <= micro_instruction[4:0];
          addr_q  <= data_addr;
          // Non-memory words commit during their EXEC cycle, so the strobe
          // is raised as the word enters EXEC.
          cv_q    <= ~(micro_instruction[25] | micro_instruction[24]);
          hold_q  <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          if (mr_q ^ mw_q) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= mw_q;
            mem_addr_q <= addr_q;
`ifdef MI_SEQUENCER_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
            state_q    <= MEM;
          end else if (mr_q & mw_q) begin
            // Illegal read+write word: flag and skip.
            err_q   <= 1'b1;
            pc_q    <= pc_inc;
            hold_q  <= 1'b0;
            state_q <= FETCH;
          end else begin
            pc_q    <= br_taken ? addr_q : pc_inc;
            hold_q  <= 1'b0;
            state_q <= FETCH;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            cv_q      <= 1'b1;
            pc_q      <= pc_inc;
            hold_q    <= 1'b0;
            state_q   <= FETCH;
          end
`ifdef MI_SEQUENCER_TIMEOUT_EN
          // Count reaches 14 at the end of the 15th unacknowledged cycle.
          else if (tmo_cnt_q == 4'd14) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            pc_q      <= pc_inc;
            hold_q    <= 1'b0;
            state_q   <= FETCH;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 4'd1;
          end
`endif
        end
        default: begin
          hold_q  <= 1'b0;
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign HOLD       = hold_q;
  assign pc         = pc_q;
  assign alu_op     = alu_q;
  assign sh         = sh_q;
  assign kmx        = kmx_q;
  assign bus_a      = bus_a_q;
  assign bus_b      = bus_b_q;
  assign bus_c      = bus_c_q;
  assign ctrl_valid = cv_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mi_sequencer.sv
// Directed bench for mi_sequencer: reset, plain commit, branches, pc wrap,
// memory read/write handshakes, illegal word, ack timeout and reset in MEM.
module tb_mi_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] micro_instruction;
  logic [10:0] data_addr;
  logic        HOLD;
  logic        zf, cy;
  logic [10:0] pc;
  logic [3:0]  alu_op;
  logic [1:0]  sh;
  logic        kmx;
  logic [4:0]  bus_a;
  logic [5:0]  bus_b, bus_c;
  logic        ctrl_valid, mem_req, mem_we;
  logic [10:0] mem_addr;
  logic        mem_ack;
  logic        err;

  int total = 0;
  int bad   = 0;

  mi_sequencer dut (
    .clk(clk), .rst_n(rst_n), .micro_instruction(micro_instruction),
    .data_addr(data_addr), .HOLD(HOLD), .zf(zf), .cy(cy), .pc(pc),
    .alu_op(alu_op), .sh(sh), .kmx(kmx), .bus_a(bus_a), .bus_b(bus_b),
    .bus_c(bus_c), .ctrl_valid(ctrl_valid), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  // Word with fixed side fields: SH=10, Kmx=1, B=2A, C=15, A=13.
  function automatic logic [32:0] mk(input logic [3:0] alu, input logic mr,
                                     input logic mw, input logic [6:0] t);
    return {alu, 2'b10, 1'b1, mr, mw, 6'h2A, 6'h15, t, 5'h13};
  endfunction

  // Present a word in FETCH and run it through FETCH and EXEC.
  task automatic run_word(input logic [32:0] w, input logic [10:0] a);
    micro_instruction = w;
    data_addr = a;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; micro_instruction = '0; data_addr = '0;
    zf = 1'b0; cy = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({HOLD, pc, ctrl_valid, mem_req, mem_we, mem_addr, err} !== 27'd0) begin
      bad++; $display("FAIL reset_ctrl got=%h exp=0", {HOLD, pc, ctrl_valid, mem_req, mem_we, mem_addr, err});
    end
    total++;
    if ({alu_op, sh, kmx, bus_a, bus_b, bus_c} !== 24'd0) begin
      bad++; $display("FAIL reset_fields got=%h exp=0", {alu_op, sh, kmx, bus_a, bus_b, bus_c});
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    micro_instruction = mk(4'b0101, 1'b0, 1'b0, 7'b0111101);
    data_addr = 11'h3AB;
    @(posedge clk); #1;
    total++;
    if ({HOLD, ctrl_valid, pc} !== {1'b1, 1'b1, 11'd0}) begin
      bad++; $display("FAIL basic_exec hold/cv/pc got=%b/%b/%h exp=1/1/000", HOLD, ctrl_valid, pc);
    end
    total++;
    if ({alu_op, sh, kmx, bus_b, bus_c, bus_a} !== {4'h5, 2'b10, 1'b1, 6'h2A, 6'h15, 5'h13}) begin
      bad++; $display("FAIL basic_fields got=%h exp=%h", {alu_op, sh, kmx, bus_b, bus_c, bus_a},
                      {4'h5, 2'b10, 1'b1, 6'h2A, 6'h15, 5'h13});
    end
    @(posedge clk); #1;
    total++;
    if ({HOLD, ctrl_valid, pc} !== {1'b0, 1'b0, 11'd1}) begin
      bad++; $display("FAIL basic_done hold/cv/pc got=%b/%b/%h exp=0/0/001", HOLD, ctrl_valid, pc);
    end
  endtask

  task automatic test_branch;
    zf = 1'b1;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b1000001), 11'h155);
    total++;
    if (pc !== 11'h155) begin bad++; $display("FAIL br_zf_taken pc got=%h exp=155", pc); end
    zf = 1'b0;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b1000001), 11'h155);
    total++;
    if (pc !== 11'h156) begin bad++; $display("FAIL br_zf_not pc got=%h exp=156", pc); end
    cy = 1'b1;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b1010000), 11'h200);
    total++;
    if (pc !== 11'h200) begin bad++; $display("FAIL br_cy_taken pc got=%h exp=200", pc); end
    cy = 1'b0;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b1010000), 11'h300);
    total++;
    if (pc !== 11'h201) begin bad++; $display("FAIL br_cy_not pc got=%h exp=201", pc); end
    zf = 1'b1; cy = 1'b1;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b0010001), 11'h400);
    total++;
    if (pc !== 11'h202) begin bad++; $display("FAIL br_no_t6 pc got=%h exp=202", pc); end
    zf = 1'b0; cy = 1'b0;
    run_word(mk(4'h0, 1'b0, 1'b0, 7'b1000000), 11'h7FF);
    total++;
    if (pc !== 11'h7FF) begin bad++; $display("FAIL br_uncond pc got=%h exp=7ff", pc); end
  endtask

  task automatic test_wrap;
    micro_instruction = mk(4'b1111, 1'b0, 1'b0, 7'd0);
    data_addr = 11'h055;
    @(posedge clk); #1;
    total++;
    if (ctrl_valid !== 1'b1) begin bad++; $display("FAIL nop_cv got=%b exp=1", ctrl_valid); end
    @(posedge clk); #1;
    total++;
    if (pc !== 11'd0) begin bad++; $display("FAIL nop_wrap pc got=%h exp=000", pc); end
  endtask

  task automatic test_mem_read;
    int hi = 0;
    micro_instruction = mk(4'h0, 1'b1, 1'b0, 7'd0);
    data_addr = 11'h07F;
    @(posedge clk); #1;
    total++;
    if ({mem_req, ctrl_valid, HOLD} !== 3'b001) begin
      bad++; $display("FAIL rd_exec req/cv/hold got=%b exp=001", {mem_req, ctrl_valid, HOLD});
    end
    mem_ack = 1'b1;           // ack in EXEC must be ignored
    repeat (5) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) hi++;
    end
    total++;
    if ({mem_we, mem_addr, ctrl_valid, HOLD} !== {1'b0, 11'h07F, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rd_mem we/addr/cv/hold got=%b/%h/%b/%b exp=0/07f/0/1", mem_we, mem_addr, ctrl_valid, HOLD);
    end
    mem_ack = 1'b1;           // ack during the fifth MEM cycle
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++;
    if (hi != 5) begin bad++; $display("FAIL rd_req_cycles got=%0d exp=5", hi); end
    total++;
    if ({mem_req, ctrl_valid, HOLD, pc} !== {1'b0, 1'b1, 1'b0, 11'd1}) begin
      bad++; $display("FAIL rd_ack req/cv/hold/pc got=%b/%b/%b/%h exp=0/1/0/001", mem_req, ctrl_valid, HOLD, pc);
    end
  endtask

  task automatic test_mem_write_fast;
    micro_instruction = mk(4'h0, 1'b0, 1'b1, 7'd0);
    data_addr = 11'h123;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 11'h123}) begin
      bad++; $display("FAIL wr_mem req/we/addr got=%b/%b/%h exp=1/1/123", mem_req, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++;
    if ({mem_req, ctrl_valid, pc} !== {1'b0, 1'b1, 11'd2}) begin
      bad++; $display("FAIL wr_ack req/cv/pc got=%b/%b/%h exp=0/1/002", mem_req, ctrl_valid, pc);
    end
  endtask

  task automatic test_illegal;
    micro_instruction = mk(4'h0, 1'b1, 1'b1, 7'd0);
    data_addr = 11'h000;
    @(posedge clk); #1;
    total++;
    if ({mem_req, ctrl_valid, err} !== 3'b000) begin
      bad++; $display("FAIL ill_exec req/cv/err got=%b exp=000", {mem_req, ctrl_valid, err});
    end
    @(posedge clk); #1;
    total++;
    if ({err, mem_req, ctrl_valid, HOLD, pc} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd3}) begin
      bad++; $display("FAIL ill_done err/req/cv/hold/pc got=%b/%b/%b/%b/%h exp=1/0/0/0/003", err, mem_req, ctrl_valid, HOLD, pc);
    end
  endtask

  // Reset pulse from any state; outputs must clear while rst_n is low.
  task automatic test_reset_pulse;
    rst_n = 1'b0;
    #1;
    total++;
    if ({HOLD, pc, ctrl_valid, mem_req, mem_we, mem_addr, err, alu_op} !== 31'd0) begin
      bad++; $display("FAIL rst_pulse got=%h exp=0", {HOLD, pc, ctrl_valid, mem_req, mem_we, mem_addr, err, alu_op});
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_timeout;
    int hi = 0;
    run_word(mk(4'h0, 1'b0, 1'b1, 7'd0), 11'h0AA);
    if (mem_req === 1'b1) hi++;
`ifdef MI_SEQUENCER_TIMEOUT_EN
    repeat (14) begin @(posedge clk); #1; if (mem_req === 1'b1) hi++; end
    total++;
    if (hi != 15) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=15", hi); end
    @(posedge clk); #1;
    total++;
    if ({mem_req, err, ctrl_valid, HOLD, pc} !== {1'b0, 1'b1, 1'b0, 1'b0, 11'd1}) begin
      bad++; $display("FAIL tmo_fire req/err/cv/hold/pc got=%b/%b/%b/%b/%h exp=0/1/0/0/001", mem_req, err, ctrl_valid, HOLD, pc);
    end
`else
    repeat (20) begin @(posedge clk); #1; if (mem_req === 1'b1) hi++; end
    total++;
    if (hi != 21) begin bad++; $display("FAIL nowait_req_cycles got=%0d exp=21", hi); end
    total++;
    if ({err, HOLD, pc} !== {1'b0, 1'b1, 11'd0}) begin
      bad++; $display("FAIL nowait_state err/hold/pc got=%b/%b/%h exp=0/1/000", err, HOLD, pc);
    end
    test_reset_pulse();
`endif
  endtask

  task automatic test_reset_in_mem;
    run_word(mk(4'h0, 1'b0, 1'b1, 7'd0), 11'h0CC);
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rmem_enter req got=%b exp=1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({mem_req, HOLD, pc, ctrl_valid} !== 14'd0) begin
      bad++; $display("FAIL rmem_async req/hold/pc/cv got=%b/%b/%h/%b exp=0/0/000/0", mem_req, HOLD, pc, ctrl_valid);
    end
    #1 rst_n = 1'b1;
    mem_ack = 1'b1;           // late ack must not commit the dropped access
    run_word(mk(4'b1111, 1'b0, 1'b0, 7'd0), 11'h000);
    mem_ack = 1'b0;
    total++;
    if ({pc, mem_req, err} !== {11'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rmem_after pc/req/err got=%h/%b/%b exp=001/0/0", pc, mem_req, err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_wrap();
    test_mem_read();
    test_mem_write_fast();
    test_illegal();
    test_reset_pulse();
    test_timeout();
    test_reset_in_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
